multiplier_arbiter: RTL

//   Shares one non-pipelined multi-cycle multiplier (valid/ready in, valid/ready out) among M requesters.

---
 rtl/mul_arb_pkg.sv | 11 +
 rtl/rr_picker.sv | 31 +++
 rtl/multiplier_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: FSM state encoding and requester-ID width.
package mul_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} mul_arb_state_t;

    // A single requester still gets a 1-bit ID so ports never collapse to zero width.
    function automatic int id_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo M.
module rr_picker
    import mul_arb_pkg::*;
#(
    parameter int M = 3,
    localparam int IW = id_width(M)
) (
    input  logic [M-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [M-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin : pick
        int k;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < M; i++) begin
            k = (int'(ptr) + i) % M;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one multi-cycle valid/ready multiplier among M requesters, one operation in flight,
// round-robin grant, result returned only to the requester that issued it.
module multiplier_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 3,
    localparam int IW = id_width(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     req_valid,
    output logic [M-1:0]     req_ready,
    input  logic [M*N-1:0]   req_a,
    input  logic [M*N-1:0]   req_b,
    output logic [M-1:0]     resp_valid,
    input  logic [M-1:0]     resp_ready,
    output logic [2*N-1:0]   resp_product,
    output logic             busy,
    output logic [IW-1:0]    grant_id,
    output logic             mul_valid_i,
    input  logic             mul_ready_i,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic             mul_valid_o,
    output logic             mul_ready_o,
    input  logic [2*N-1:0]   mul_product
);

    mul_arb_state_t state, state_next;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_next;
    logic [M-1:0]   pick_grant;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic           accept;
    logic           resp_done;

    rr_picker #(.M(M)) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign accept    = (state == S_IDLE) && pick_any;
    assign resp_done = (state == S_RESPOND) && resp_ready[grant_id];
    // Next search starts just past the winner so a continuously requesting client cannot be skipped.
    assign ptr_next  = (pick_idx == IW'(M - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        resp_valid  = '0;
        mul_valid_i = 1'b0;
        mul_ready_o = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = pick_grant;
                if (pick_any) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                mul_valid_i = 1'b1;
                if (mul_ready_i) state_next = S_WAIT;
            end
            S_WAIT: begin
                mul_ready_o = 1'b1;
                if (mul_valid_o) state_next = S_RESPOND;
            end
            S_RESPOND: begin
                for (int k = 0; k < M; k++) resp_valid[k] = (grant_id == IW'(k));
                if (resp_ready[grant_id]) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            resp_product <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mul_a    <= req_a[pick_idx*N +: N];
                mul_b    <= req_b[pick_idx*N +: N];
                grant_id <= pick_idx;
                ptr      <= ptr_next;
                busy     <= 1'b1;
            end else if (resp_done) begin
                busy <= 1'b0;
            end
            if (state == S_WAIT && mul_valid_o) resp_product <= mul_product;
        end
    end

endmodule
